// File: rtl/piso_buffer1d_pkg.sv
// piso_buffer1d_pkg: shared CFA pixel/window defaults, FSM states and packed-window slot indexing
package piso_buffer1d_pkg;
  localparam int DATA_BIT_WIDTH = 12;
  localparam int BUFFER_SIZE = 5;
  typedef enum logic {IDLE, DRAIN} state_t;
  function automatic int slot_lsb(input int i, input int w);
    return i * w;
  endfunction
endpackage

// File: rtl/piso_buffer1d.sv
// piso_buffer1d: parallel-in serial-out unload buffer, one packed window in, one pixel per cycle out
module piso_buffer1d
  import piso_buffer1d_pkg::*;
#(
  parameter int DataBitWidth = DATA_BIT_WIDTH,
  parameter int BufferSize = BUFFER_SIZE,
  localparam int CW = $clog2(BufferSize + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 load_valid,
  output logic                                 load_ready,
  input  logic [BufferSize*DataBitWidth-1:0]   d_in,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [DataBitWidth-1:0]       d_out,
  output logic                                 out_last,
  output logic [CW-1:0]                        remaining
);
  localparam logic [CW-1:0] FULL = CW'(BufferSize);
  state_t r_state, w_next;
  logic signed [DataBitWidth-1:0] r_mem [BufferSize];
  logic [CW-1:0] r_remaining;
  logic w_load, w_out, w_last;
  assign w_last     = r_remaining == CW'(1);
  assign out_valid  = r_remaining != '0;
  assign out_last   = w_last;
  assign remaining  = r_remaining;
  assign d_out      = r_mem[0];
  assign w_out      = out_valid & out_ready;
  assign load_ready = ~flush & ((r_state == IDLE) | (w_out & w_last));
  assign w_load     = load_valid & load_ready;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // next state: flush and the final pixel return to IDLE, a load always enters DRAIN
  always_comb
    w_next = flush ? IDLE : w_load ? DRAIN : (w_out && w_last) ? IDLE : r_state;
  // pixel count; a load coinciding with the last pixel reloads instead of decrementing
  always_ff @(posedge clk or posedge rst)
    if (rst) r_remaining <= '0;
    else if (flush) r_remaining <= '0;
    else if (w_load) r_remaining <= FULL;
    else if (w_out) r_remaining <= r_remaining - CW'(1);
  // storage: parallel load wins over shift, shifting zeros in behind the oldest pixel
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < BufferSize; i++) r_mem[i] <= '0;
    else if (flush) for (int i = 0; i < BufferSize; i++) r_mem[i] <= '0;
    else if (w_load)
      for (int i = 0; i < BufferSize; i++)
        r_mem[i] <= d_in[slot_lsb(i, DataBitWidth) +: DataBitWidth];
    else if (w_out) begin
      for (int k = 0; k < BufferSize - 1; k++) r_mem[k] <= r_mem[k+1];
      r_mem[BufferSize-1] <= '0;
    end
endmodule
